// File: rtl/panel_serial_scheduler_pkg.sv
// Shared types, sizes and bit-mapping helpers for the panel serial scheduler.
package panel_serial_pkg;

    localparam int CHAIN_BITS   = 16;
    localparam int N_OUT_CHAINS = 4;
    localparam int N_IN_CHAINS  = 5;
    localparam int OUT_W        = N_OUT_CHAINS * CHAIN_BITS;
    localparam int IN_W         = N_IN_CHAINS * CHAIN_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH,
        ST_GAP
    } state_t;

    // Serial data bit for every 595 chain at bit index k (MSB of each chain first).
    function automatic logic [N_OUT_CHAINS-1:0] out_bits(
        input logic [OUT_W-1:0] word,
        input logic [3:0]       k
    );
        logic [N_OUT_CHAINS-1:0] b;
        logic [5:0]              idx;
        b = '0;
        for (int i = 0; i < N_OUT_CHAINS; i++) begin
            idx  = 6'(CHAIN_BITS * i + CHAIN_BITS - 1 - int'(k));
            b[i] = word[idx];
        end
        return b;
    endfunction

    // Drop the QH bits of all 165 chains into position 15-k of their chain slice.
    function automatic logic [IN_W-1:0] in_insert(
        input logic [IN_W-1:0]        cur,
        input logic [N_IN_CHAINS-1:0] qh,
        input logic [3:0]             k
    );
        logic [IN_W-1:0] r;
        logic [6:0]      idx;
        r = cur;
        for (int j = 0; j < N_IN_CHAINS; j++) begin
            idx    = 7'(CHAIN_BITS * j + CHAIN_BITS - 1 - int'(k));
            r[idx] = qh[j];
        end
        return r;
    endfunction

endpackage

// File: rtl/panel_serial_scheduler_if.sv
// Pin bundle between the scheduler and the 595 / 165 expansion chains.
interface panel_serial_scheduler_if;

    logic serial_out_srclk;
    logic serial_out_rclk;
    logic serial_out_ser_0;
    logic serial_out_ser_1;
    logic serial_out_ser_2;
    logic serial_out_ser_3;
    logic serial_in_rclk;
    logic serial_in_shldn;
    logic serial_in_ser_0;
    logic serial_in_ser_1;
    logic serial_in_ser_2;
    logic serial_in_ser_3;
    logic serial_in_ser_4;

    // Scheduler side: drives clocks, load and 595 data, receives 165 QH returns.
    modport master (
        output serial_out_srclk, serial_out_rclk,
        output serial_out_ser_0, serial_out_ser_1, serial_out_ser_2, serial_out_ser_3,
        output serial_in_rclk, serial_in_shldn,
        input  serial_in_ser_0, serial_in_ser_1, serial_in_ser_2, serial_in_ser_3,
        input  serial_in_ser_4
    );

    // Chain side: the shift-register hardware (or its model).
    modport slave (
        input  serial_out_srclk, serial_out_rclk,
        input  serial_out_ser_0, serial_out_ser_1, serial_out_ser_2, serial_out_ser_3,
        input  serial_in_rclk, serial_in_shldn,
        output serial_in_ser_0, serial_in_ser_1, serial_in_ser_2, serial_in_ser_3,
        output serial_in_ser_4
    );

endinterface

// File: rtl/panel_serial_scheduler_timer.sv
// Shared phase timer: down-counts CLK_DIV cycles per serial phase, or GAP cycles
// between frames, and flags the last cycle of the current phase.
module serial_phase_timer #(
    parameter int CLK_DIV = 2,
    parameter int GAP     = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_gap,
    output logic phase_last
);

    localparam int MAXV = (CLK_DIV > GAP) ? CLK_DIV : GAP;
    localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;

    logic [CW-1:0] cnt;

    // Reload on every phase change, otherwise count down and rest at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_gap ? CW'(GAP - 1) : CW'(CLK_DIV - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign phase_last = (cnt == '0);

endmodule

// File: rtl/panel_serial_scheduler.sv
// Frame scheduler for the front-panel chains: shifts a 64-bit display word into
// four 595 chains while sampling an 80-bit switch word from five 165 chains.
module panel_serial_scheduler
    import panel_serial_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int GAP     = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [OUT_W-1:0]                  out_data,
    output logic [IN_W-1:0]                   in_data,
    output logic                              in_valid,
    output logic                              busy,
    panel_serial_scheduler_if.master          sif,
    output state_t                            dbg_state
);

    // in_valid is a one-cycle strobe with no ready: in_data is valid from the
    // strobe cycle until the next strobe, and the consumer cannot stall it.

    state_t                  state;
    logic [3:0]              bit_k;
    logic [OUT_W-1:0]        snap;
    logic [IN_W-1:0]         in_shift;
    logic [N_OUT_CHAINS-1:0] ser_q;
    logic                    shift_clk_q;
    logic                    out_rclk_q;
    logic                    shldn_q;
    logic                    phase_last;
    logic                    timer_load;
    logic                    timer_load_gap;
    logic [N_IN_CHAINS-1:0]  qh;

    assign qh = {sif.serial_in_ser_4, sif.serial_in_ser_3, sif.serial_in_ser_2,
                 sif.serial_in_ser_1, sif.serial_in_ser_0};

    // Restart the timer on every state transition; only LATCH->GAP uses GAP.
    always_comb begin
        timer_load     = 1'b0;
        timer_load_gap = 1'b0;
        if (state == ST_IDLE) begin
            timer_load = enable;
        end else begin
            timer_load     = phase_last;
            timer_load_gap = (state == ST_LATCH);
        end
    end

    serial_phase_timer #(
        .CLK_DIV (CLK_DIV),
        .GAP     (GAP)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_gap   (timer_load_gap),
        .phase_last (phase_last)
    );

    // Frame FSM; every pin is registered at the transition into the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_k       <= '0;
            snap        <= '0;
            in_shift    <= '0;
            in_data     <= '0;
            in_valid    <= 1'b0;
            busy        <= 1'b0;
            ser_q       <= '0;
            shift_clk_q <= 1'b0;
            out_rclk_q  <= 1'b0;
            shldn_q     <= 1'b1;
        end else begin
            in_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state   <= ST_LOAD;
                        snap    <= out_data;
                        shldn_q <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (phase_last) begin
                        state   <= ST_SHIFT_LO;
                        bit_k   <= '0;
                        shldn_q <= 1'b1;
                        ser_q   <= out_bits(snap, 4'd0);
                    end
                end
                ST_SHIFT_LO: begin
                    if (phase_last) begin
                        state       <= ST_SHIFT_HI;
                        in_shift    <= in_insert(in_shift, qh, bit_k);
                        shift_clk_q <= 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (phase_last) begin
                        shift_clk_q <= 1'b0;
                        if (bit_k == 4'd15) begin
                            state      <= ST_LATCH;
                            out_rclk_q <= 1'b1;
                        end else begin
                            state <= ST_SHIFT_LO;
                            bit_k <= bit_k + 4'd1;
                            ser_q <= out_bits(snap, bit_k + 4'd1);
                        end
                    end
                end
                ST_LATCH: begin
                    if (phase_last) begin
                        state      <= ST_GAP;
                        out_rclk_q <= 1'b0;
                        in_data    <= in_shift;
                        in_valid   <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (phase_last) begin
                        if (enable) begin
                            state   <= ST_LOAD;
                            snap    <= out_data;
                            shldn_q <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state            = state;
    assign sif.serial_out_srclk = shift_clk_q;
    assign sif.serial_in_rclk   = shift_clk_q;
    assign sif.serial_out_rclk  = out_rclk_q;
    assign sif.serial_in_shldn  = shldn_q;
    assign sif.serial_out_ser_0 = ser_q[0];
    assign sif.serial_out_ser_1 = ser_q[1];
    assign sif.serial_out_ser_2 = ser_q[2];
    assign sif.serial_out_ser_3 = ser_q[3];

endmodule

// File: tb/tb_panel_serial_scheduler.sv
// Bench for panel_serial_scheduler: two instances (default and minimum timing)
// with behavioural 595 / 165 chain models and a frame-level reference model.
module tb_panel_serial_scheduler;
    import panel_serial_pkg::*;

    localparam int CD0 = 2;
    localparam int GP0 = 4;
    localparam int CD1 = 1;
    localparam int GP1 = 1;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset_a    [2];
    logic        enable_a   [2];
    logic [63:0] out_data_a [2];
    logic [79:0] sw_a       [2];

    logic [79:0] in_data_a  [2];
    logic        in_valid_a [2];
    logic        busy_a     [2];
    logic        shldn_a    [2];
    logic        sclk_a     [2];
    logic        orclk_a    [2];
    logic        irclk_a    [2];
    logic [3:0]  ser_a      [2];
    logic [63:0] lat_a      [2];
    state_t      st_a       [2];

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int CD = (g == 0) ? CD0 : CD1;
        localparam int GP = (g == 0) ? GP0 : GP1;

        panel_serial_scheduler_if sif ();
        logic [79:0]     in_data_l;
        logic            in_valid_l;
        logic            busy_l;
        state_t          st_l;
        logic [3:0][15:0] sh595  = '0;
        logic [3:0][15:0] lat595 = '0;
        logic [4:0][15:0] sh165  = '0;
        logic            sclk_prev  = 1'b0;
        logic            orclk_prev = 1'b0;
        logic            irclk_prev = 1'b0;
        logic [3:0]      serv;

        panel_serial_scheduler #(.CLK_DIV(CD), .GAP(GP)) dut (
            .clk       (clk),
            .reset     (reset_a[g]),
            .enable    (enable_a[g]),
            .out_data  (out_data_a[g]),
            .in_data   (in_data_l),
            .in_valid  (in_valid_l),
            .busy      (busy_l),
            .sif       (sif),
            .dbg_state (st_l)
        );

        assign serv = {sif.serial_out_ser_3, sif.serial_out_ser_2,
                       sif.serial_out_ser_1, sif.serial_out_ser_0};

        // 595 chains shift on srclk rise and latch on rclk rise; 165 chains load
        // while shldn is low and shift on rclk rise, QH being bit 15.
        always @(negedge clk) begin
            if (sif.serial_out_srclk === 1'b1 && sclk_prev === 1'b0)
                for (int i = 0; i < 4; i++) sh595[i] <= {sh595[i][14:0], serv[i]};
            if (sif.serial_out_rclk === 1'b1 && orclk_prev === 1'b0)
                lat595 <= sh595;
            if (sif.serial_in_shldn === 1'b0)
                sh165 <= sw_a[g];
            else if (sif.serial_in_rclk === 1'b1 && irclk_prev === 1'b0)
                for (int j = 0; j < 5; j++) sh165[j] <= {sh165[j][14:0], 1'b0};
            sclk_prev  <= sif.serial_out_srclk;
            orclk_prev <= sif.serial_out_rclk;
            irclk_prev <= sif.serial_in_rclk;
        end

        assign sif.serial_in_ser_0 = sh165[0][15];
        assign sif.serial_in_ser_1 = sh165[1][15];
        assign sif.serial_in_ser_2 = sh165[2][15];
        assign sif.serial_in_ser_3 = sh165[3][15];
        assign sif.serial_in_ser_4 = sh165[4][15];

        assign in_data_a[g]  = in_data_l;
        assign in_valid_a[g] = in_valid_l;
        assign busy_a[g]     = busy_l;
        assign st_a[g]       = st_l;
        assign shldn_a[g]    = sif.serial_in_shldn;
        assign sclk_a[g]     = sif.serial_out_srclk;
        assign orclk_a[g]    = sif.serial_out_rclk;
        assign irclk_a[g]    = sif.serial_in_rclk;
        assign ser_a[g]      = serv;
        assign lat_a[g]      = lat595;
    end

    // scoreboard compare
    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_pins(input int g, input string tag);
        check(tag, 80'({st_a[g], busy_a[g], shldn_a[g], in_valid_a[g], sclk_a[g],
                        orclk_a[g], irclk_a[g], ser_a[g]}),
                   80'({ST_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0}));
    endtask

    // driver / monitor helpers, all sampled on the falling edge
    task automatic wait_load(input int g, input int budget, output int t);
        logic prev;
        bit   found;
        found = 0;
        t     = -1;
        prev  = shldn_a[g];
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (prev === 1'b1 && shldn_a[g] === 1'b0) begin
                found = 1;
                t     = cyc;
            end
            prev = shldn_a[g];
        end
        if (!found) check("load_timeout", 80'd0, 80'd1);
    endtask

    task automatic wait_valid(input int g, input int budget, output int t);
        bit found;
        found = 0;
        t     = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (in_valid_a[g] === 1'b1) begin
                found = 1;
                t     = cyc;
            end
        end
        if (!found) check("valid_timeout", 80'd0, 80'd1);
    endtask

    task automatic randomize_inputs(input int g);
        out_data_a[g] = {$urandom(), $urandom()};
        sw_a[g]       = {16'($urandom()), $urandom(), $urandom()};
    endtask

    // Runs n frames starting at the LOAD-entry cycle t0 whose inputs are the
    // current out_data/sw; fresh random inputs are applied after each in_valid.
    task automatic frames(input int g, input int n, input int cd, input int gp, inout int t0);
        int          t1;
        int          t2;
        logic [79:0] ein;
        logic [63:0] eout;
        for (int f = 0; f < n; f++) begin
            exp_q.push_back(out_data_a[g]);
            ein = sw_a[g];
            wait_valid(g, 34 * cd + gp + 10, t1);
            check("valid_latency", 80'(t1 - t0), 80'(34 * cd));
            check("in_data", in_data_a[g], ein);
            eout = exp_q.pop_front();
            check("chains_595", 80'(lat_a[g]), 80'(eout));
            randomize_inputs(g);
            wait_load(g, gp + 10, t2);
            check("frame_len", 80'(t2 - t0), 80'(34 * cd + gp));
            t0 = t2;
        end
    endtask

    initial begin
        int          t0;
        int          t1;
        int          t2;
        int          lows;
        logic [63:0] pre;
        logic [63:0] word_a;
        logic [15:0] exp_chain [4];
        exp_chain = '{16'hA5C3, 16'h89AB, 16'h4567, 16'h0123};

        for (int g = 0; g < 2; g++) begin
            reset_a[g]    = 1'b1;
            enable_a[g]   = 1'b0;
            out_data_a[g] = '0;
            sw_a[g]       = '0;
        end
        repeat (3) @(negedge clk);
        check_idle_pins(0, "reset_pins0");
        check_idle_pins(1, "reset_pins1");
        check("reset_in_data0", in_data_a[0], 80'd0);
        reset_a[0] = 1'b0;
        reset_a[1] = 1'b0;
        @(negedge clk);

        // Basic frame and input sampling with the default timing.
        out_data_a[0] = 64'h0123_4567_89AB_A5C3;
        sw_a[0]       = 80'h0F0F_8000_0001_FFFF_1234;
        enable_a[0]   = 1'b1;
        wait_load(0, 10, t0);
        check("busy_rise", 80'(busy_a[0]), 80'd1);
        wait_valid(0, 200, t1);
        check("valid_at_68", 80'(t1 - t0), 80'd68);
        check("in_data_basic", in_data_a[0], 80'h0F0F_8000_0001_FFFF_1234);
        for (int i = 0; i < 4; i++)
            check($sformatf("chain%0d_basic", i), 80'(lat_a[0][16*i +: 16]), 80'(exp_chain[i]));
        @(negedge clk);
        check("valid_one_cycle", 80'(in_valid_a[0]), 80'd0);
        wait_load(0, 20, t2);
        check("frame_len_72", 80'(t2 - t0), 80'd72);
        t0 = t2;

        // Random back-to-back frames.
        frames(0, 3, CD0, GP0, t0);

        // Snapshot: out_data changes during SHIFT_LO of bit 5.
        pre = out_data_a[0];
        repeat (CD0 + 2 * CD0 * 5) @(negedge clk);
        out_data_a[0] = '1;
        wait_valid(0, 100, t1);
        check("snap_pre_word", 80'(lat_a[0]), 80'(pre));
        wait_load(0, 20, t0);
        wait_valid(0, 100, t1);
        check("snap_next_ones", 80'(lat_a[0]), 80'(64'hFFFF_FFFF_FFFF_FFFF));

        // Enable drop at bit 8.
        wait_load(0, 20, t0);
        repeat (CD0 + 2 * CD0 * 8) @(negedge clk);
        enable_a[0] = 1'b0;
        wait_valid(0, 100, t1);
        check("drop_valid_latency", 80'(t1 - t0), 80'd68);
        check("drop_frame_data", 80'(lat_a[0]), 80'(64'hFFFF_FFFF_FFFF_FFFF));
        repeat (GP0 - 1) @(negedge clk);
        check("drop_busy_hold", 80'(busy_a[0]), 80'd1);
        @(negedge clk);
        check("drop_busy_fall", 80'(busy_a[0]), 80'd0);
        check("drop_idle", 80'(st_a[0]), 80'(ST_IDLE));
        lows = 0;
        repeat (80) begin
            @(negedge clk);
            if (shldn_a[0] !== 1'b1) lows++;
        end
        check("drop_no_reload", 80'(lows), 80'd0);

        // Reset in the middle of shifting bit 10.
        randomize_inputs(0);
        word_a      = out_data_a[0];
        enable_a[0] = 1'b1;
        wait_load(0, 10, t0);
        wait_valid(0, 100, t1);
        check("pre_reset_lat", 80'(lat_a[0]), 80'(word_a));
        out_data_a[0] = ~word_a;
        wait_load(0, 20, t0);
        repeat (CD0 + 2 * CD0 * 10) @(negedge clk);
        reset_a[0]  = 1'b1;
        enable_a[0] = 1'b0;
        @(negedge clk);
        check_idle_pins(0, "reset_mid_pins");
        check("reset_mid_in_data", in_data_a[0], 80'd0);
        check("reset_mid_lat_kept", 80'(lat_a[0]), 80'(word_a));
        reset_a[0] = 1'b0;
        @(negedge clk);

        // Minimum timing: CLK_DIV=1, GAP=1.
        randomize_inputs(1);
        enable_a[1] = 1'b1;
        wait_load(1, 10, t0);
        frames(1, 4, CD1, GP1, t0);
        enable_a[1] = 1'b0;
        lows = 0;
        for (int i = 0; i < 100 && busy_a[1] !== 1'b0; i++) begin
            @(negedge clk);
            lows++;
        end
        check("min_busy_fall", 80'(busy_a[1]), 80'd0);
        check("min_idle", 80'(st_a[1]), 80'(ST_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
